// File: rtl/display_capture_if.sv
// ============================================================================
// Module  : display_capture_if
// Purpose : Scan-bus inputs and frame outputs of display_capture.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface display_capture_if #(
  parameter int GS = 8
);
  logic [GS-1:0]    row_val_i;
  logic [GS-1:0]    col_val_i;
  logic [GS*GS-1:0] frame_o;
  logic             frame_valid_o;
  logic [7:0]       frame_cnt_o;
  logic             err_o;
  logic             stale_o;

  modport master (
    output row_val_i, col_val_i,
    input  frame_o, frame_valid_o, frame_cnt_o, err_o, stale_o
  );

  modport slave (
    input  row_val_i, col_val_i,
    output frame_o, frame_valid_o, frame_cnt_o, err_o, stale_o
  );
endinterface

`default_nettype wire

// File: rtl/display_capture.sv
// ============================================================================
// Module  : display_capture
// Purpose : Decodes a row-multiplexed LED scan bus and publishes whole frames.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module display_capture #(
  parameter int GS      = 8,
  parameter int STABLE  = 2,
  parameter int TIMEOUT = 1024
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  display_capture_if.slave  bus
);

  localparam int SW = $clog2(STABLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t            r_state;
  logic [GS-1:0]     r_row_q;
  logic [GS-1:0]     r_col_q;
  logic [SW-1:0]     r_stab;
  logic [TW-1:0]     r_to;
  logic [GS*GS-1:0]  r_shadow;
  logic [GS-1:0]     r_mask;
  logic [GS*GS-1:0]  r_frame;
  logic              r_valid;
  logic [7:0]        r_cnt;
  logic              r_err;
  logic              r_stale;

  logic              w_same;
  logic              w_row_chg;
  logic              w_row_blank;
  logic              w_onehot;
  logic              w_capture;
  logic              w_write;
  logic              w_done;
  logic [SW-1:0]     w_stab_nxt;
  logic [TW-1:0]     w_to_nxt;
  logic [GS*GS-1:0]  w_shadow_nxt;
  logic [GS-1:0]     w_mask_nxt;

  assign w_same      = (bus.row_val_i == r_row_q) && (bus.col_val_i == r_col_q);
  assign w_row_chg   = (bus.row_val_i != r_row_q);
  assign w_row_blank = (bus.row_val_i == '0);
  assign w_onehot    = (r_row_q != '0) && ((r_row_q & (r_row_q - GS'(1))) == '0);
  // r_stab >= STABLE-1 means the registered pair has been seen STABLE times in a row
  assign w_capture   = (r_state == S_SETTLE) && (r_stab >= SW'(STABLE - 1));
  assign w_write     = w_capture && w_onehot;
  assign w_done      = w_write && (w_mask_nxt == '1);

  assign w_stab_nxt  = !w_same                  ? '0     :
                       (r_stab == SW'(STABLE))  ? r_stab : r_stab + SW'(1);
  assign w_to_nxt    = w_done                   ? '0     :
                       (r_to == TW'(TIMEOUT))   ? r_to   : r_to + TW'(1);

  always_comb begin
    w_shadow_nxt = r_shadow;
    w_mask_nxt   = r_mask;
    if (w_write) begin
      for (int r = 0; r < GS; r++) begin
        if (r_row_q[r]) begin
          w_shadow_nxt[r*GS +: GS] = r_col_q;
          w_mask_nxt[r]            = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_row_q  <= '0;
      r_col_q  <= '0;
      r_stab   <= '0;
      r_to     <= '0;
      r_shadow <= '0;
      r_mask   <= '0;
      r_frame  <= '0;
      r_valid  <= 1'b0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_stale  <= 1'b0;
    end else begin
      r_row_q  <= bus.row_val_i;
      r_col_q  <= bus.col_val_i;
      r_stab   <= w_stab_nxt;
      r_to     <= w_to_nxt;
      r_stale  <= (w_to_nxt == TW'(TIMEOUT));
      r_valid  <= w_done;
      r_shadow <= w_shadow_nxt;
      r_mask   <= w_done ? '0 : w_mask_nxt;
      if (w_done) begin
        r_frame <= w_shadow_nxt;
        r_cnt   <= r_cnt + 8'd1;
      end
      if (w_capture && !w_onehot) begin
        r_err <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_row_blank) r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          // A row leaving on the capture edge must not be swallowed by HOLD
          if (w_capture) begin
            if (!w_row_chg)       r_state <= S_HOLD;
            else if (w_row_blank) r_state <= S_IDLE;
            else                  r_state <= S_SETTLE;
          end else if (w_row_blank) begin
            r_state <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (w_row_chg) r_state <= w_row_blank ? S_IDLE : S_SETTLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.frame_o       = r_frame;
  assign bus.frame_valid_o = r_valid;
  assign bus.frame_cnt_o   = r_cnt;
  assign bus.err_o         = r_err;
  assign bus.stale_o       = r_stale;

endmodule

`default_nettype wire

// File: tb/tb_display_capture.sv
// ============================================================================
// Module  : tb_display_capture
// Purpose : Self-checking bench for display_capture against a scan-level model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_display_capture;

  localparam int GS      = 8;
  localparam int STABLE  = 2;
  localparam int TIMEOUT = 16;
  localparam int VW      = GS*GS + 11;

  logic clk = 1'b0;
  logic rst = 1'b1;

  display_capture_if #(.GS(GS)) bus ();

  display_capture #(.GS(GS), .STABLE(STABLE), .TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: a row "visit" is a run of cycles with one row value; it is captured
  // once, when its pair has been seen STABLE times running, one edge later.
  logic [GS-1:0] m_prev_row, m_prev_col, m_prow, m_pcol;
  int            m_same;
  bit            m_capt, m_pend;
  logic [GS-1:0] m_sh [GS];
  logic [GS-1:0] m_fr [GS];
  bit            m_got [GS];
  bit            m_valid, m_err;
  int            m_cnt, m_to;

  typedef struct {
    logic [GS-1:0] row;
    logic [GS-1:0] col;
    logic          exp_valid;
    logic [7:0]    exp_cnt;
  } vec_t;

  vec_t vec [32];

  function automatic int onehot_idx(input logic [GS-1:0] v);
    int idx = -1;
    if ($countones(v) == 1)
      for (int i = 0; i < GS; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  task automatic model_edge(input bit r, input logic [GS-1:0] row, input logic [GS-1:0] col);
    int  idx;
    bit  all;
    if (r) begin
      m_prev_row = '0; m_prev_col = '0; m_prow = '0; m_pcol = '0;
      m_same = 0; m_capt = 0; m_pend = 0;
      for (int i = 0; i < GS; i++) begin m_sh[i] = '0; m_fr[i] = '0; m_got[i] = 0; end
      m_valid = 0; m_err = 0; m_cnt = 0; m_to = 0;
      return;
    end
    m_valid = 0;
    if (m_pend) begin
      idx = onehot_idx(m_prow);
      if (idx < 0) m_err = 1;
      else begin
        m_sh[idx]  = m_pcol;
        m_got[idx] = 1;
        all = 1;
        for (int i = 0; i < GS; i++) if (!m_got[i]) all = 0;
        if (all) begin
          for (int i = 0; i < GS; i++) begin m_fr[i] = m_sh[i]; m_got[i] = 0; end
          m_valid = 1;
          m_cnt   = (m_cnt + 1) % 256;
        end
      end
      m_pend = 0;
    end
    m_to = m_valid ? 0 : ((m_to + 1 > TIMEOUT) ? TIMEOUT : m_to + 1);
    if (row == m_prev_row && col == m_prev_col) m_same++;
    else m_same = 1;
    if (row != m_prev_row) m_capt = 0;
    m_prev_row = row;
    m_prev_col = col;
    if (row != '0 && !m_capt && m_same >= STABLE) begin
      m_pend = 1; m_prow = row; m_pcol = col; m_capt = 1;
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [GS*GS-1:0] f;
    for (int r = 0; r < GS; r++)
      for (int c = 0; c < GS; c++) f[r*GS + c] = m_fr[r][c];
    return {f, m_valid, 8'(m_cnt), m_err, (m_to == TIMEOUT)};
  endfunction

  function automatic logic [VW-1:0] act_vec();
    return {bus.frame_o, bus.frame_valid_o, bus.frame_cnt_o, bus.err_o, bus.stale_o};
  endfunction

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input bit r, input logic [GS-1:0] row, input logic [GS-1:0] col);
    rst = r;
    bus.row_val_i = row;
    bus.col_val_i = col;
    @(posedge clk);
    model_edge(r, row, col);
    #1;
    check("model", act_vec(), exp_vec());
  endtask

  task automatic scan(input int first, input int last, input int hold);
    for (int r = first; r <= last; r++)
      for (int k = 0; k < hold; k++)
        step(1'b0, GS'(1) << r, GS'(8'hA5 ^ r));
  endtask

  task automatic blanks(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [GS-1:0] row, col;
    int            hold;

    bus.row_val_i = '0;
    bus.col_val_i = '0;
    model_edge(1'b1, '0, '0);

    // Reset with garbage on the bus
    for (int k = 0; k < 3; k++) step(1'b1, GS'($urandom), GS'($urandom));
    check("reset_outputs", act_vec(), VW'(0));

    // Clean scan: frame strobe lands STABLE+1 edges after row 7 first appears
    for (int i = 0; i < 32; i++) begin
      vec[i].row       = GS'(1) << (i / 4);
      vec[i].col       = GS'(8'hA5 ^ (i / 4));
      vec[i].exp_valid = (i == 30);
      vec[i].exp_cnt   = (i >= 30) ? 8'd1 : 8'd0;
    end
    for (int i = 0; i < 32; i++) begin
      step(1'b0, vec[i].row, vec[i].col);
      check("table_valid_cnt", VW'({bus.frame_valid_o, bus.frame_cnt_o}),
            VW'({vec[i].exp_valid, vec[i].exp_cnt}));
    end
    for (int r = 0; r < GS; r++)
      check("clean_frame_row", VW'(bus.frame_o[r*GS +: GS]), VW'(GS'(8'hA5 ^ r)));

    // Glitch: a single-cycle row 3 is rejected
    step(1'b1, '0, '0);
    scan(0, 2, 3);
    scan(3, 3, 1);
    scan(4, 7, 3);
    blanks(3);
    check("glitch_no_frame", VW'(bus.frame_cnt_o), VW'(0));
    scan(3, 3, 2);
    blanks(2);
    check("glitch_then_frame", VW'(bus.frame_cnt_o), VW'(1));

    // Multi-hot row: sticky error, no mask bits
    for (int k = 0; k < 4; k++) step(1'b0, GS'(8'h03), GS'(8'hFF));
    blanks(1);
    check("multihot_err", VW'(bus.err_o), VW'(1));
    scan(0, 7, 4);
    blanks(2);
    check("multihot_err_sticky", VW'(bus.err_o), VW'(1));
    check("multihot_then_frame", VW'(bus.frame_cnt_o), VW'(2));

    // Reset mid-frame discards the partial frame
    step(1'b1, '0, '0);
    scan(0, 4, 3);
    step(1'b1, '0, '0);
    scan(5, 7, 3);
    blanks(3);
    check("midreset_cnt", VW'(bus.frame_cnt_o), VW'(0));
    check("midreset_frame", VW'(bus.frame_o), VW'(0));

    // Randomized scan traffic
    step(1'b1, '0, '0);
    for (int seg = 0; seg < 700; seg++) begin
      case ($urandom_range(0, 9))
        0:       row = '0;
        1:       row = (GS'(3) << $urandom_range(0, GS-2)) | GS'($urandom);
        default: row = GS'(1) << $urandom_range(0, GS-1);
      endcase
      col  = GS'($urandom);
      hold = $urandom_range(1, 4);
      for (int k = 0; k < hold; k++) begin
        if ($urandom_range(0, 7) == 0) col = GS'($urandom);
        step($urandom_range(0, 299) == 0, row, col);
      end
    end

    // Timeout, then 256 frames to wrap the counter
    step(1'b1, '0, '0);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, '0, '0);
      check("stale_timing", VW'(bus.stale_o), VW'(k >= TIMEOUT));
    end
    for (int f = 0; f < 256; f++) scan(0, 7, 2);
    blanks(1);
    check("wrap_valid", VW'({bus.frame_valid_o, bus.stale_o}), VW'(2'b10));
    check("wrap_cnt", VW'(bus.frame_cnt_o), VW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
